// File: rtl/alu_issue_if.sv
// ---------------------------------------------------------------------------
// alu_issue_if
// Request/response bundle between the ALU requesters and alu_issue_arbiter.
//   req_valid / req_ready : per-requester valid/ready handshake (ready is one-hot)
//   req_op/a/b/tag        : packed per-requester operands, requester i at slice i
//   rsp_valid             : one-hot owner of the response presented this cycle
//   rsp_data/flags/tag/err: result, {carry,neg,ovf,zero}, echoed tag, illegal opcode
// master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface alu_issue_if #(
   parameter int NUM_REQ = 2,
   parameter int TAG_W   = 4
);
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [4*NUM_REQ-1:0]     req_op;
   logic [16*NUM_REQ-1:0]    req_a;
   logic [16*NUM_REQ-1:0]    req_b;
   logic [TAG_W*NUM_REQ-1:0] req_tag;
   logic [NUM_REQ-1:0]       rsp_valid;
   logic [15:0]              rsp_data;
   logic [3:0]               rsp_flags;
   logic [TAG_W-1:0]         rsp_tag;
   logic                     rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, req_tag,
      input  req_ready, rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, req_tag,
      output req_ready, rsp_valid, rsp_data, rsp_flags, rsp_tag, rsp_err
   );
endinterface

// File: rtl/alu_issue_arbiter.sv
// ---------------------------------------------------------------------------
// alu_issue_arbiter
// Shares one registered 16-bit ALU between NUM_REQ requesters. Round-robin
// grant, one op per cycle, two-stage tracking (S1 issue regs, S2 aligned with
// the ALU output register), response returned to the owner two cycles after
// accept. Zero flag is regenerated from the result; illegal opcodes never
// reach the ALU and come back with rsp_err set.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : drop in-flight ops, block grants this cycle
//   bus          : requester handshake and response (alu_issue_if.slave)
//   alu_op_o/a/b : operands to the ALU (op 0 = idle)
//   alu_out_i    : registered ALU result
//   alu_flags_i  : registered ALU flags {carry,neg,ovf,zero}
// ---------------------------------------------------------------------------
module alu_issue_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int TAG_W   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   alu_issue_if.slave  bus,
   output logic [3:0]  alu_op_o,
   output logic [15:0] alu_a_o,
   output logic [15:0] alu_b_o,
   input  logic [15:0] alu_out_i,
   input  logic [3:0]  alu_flags_i
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   function automatic logic illegal_op(input logic [3:0] op);
      case (op)
         4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd15: return 1'b0;
         default:                                          return 1'b1;
      endcase
   endfunction

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] winner;
   logic             any_valid;
   logic             accept;
   int unsigned      idx;

   // S1: issue registers
   logic             v1;
   logic [PTR_W-1:0] id1;
   logic [3:0]       op1;
   logic [15:0]      a1;
   logic [15:0]      b1;
   logic [TAG_W-1:0] tag1;
   logic             err1;

   // S2: aligned with the ALU's registered result
   logic             v2;
   logic [PTR_W-1:0] id2;
   logic [TAG_W-1:0] tag2;
   logic             err2;

   // Round-robin search. Walking the offsets from the far end downward lets the
   // closest valid requester to ptr overwrite any farther one, so no break is needed.
   // NOTE: every always_comb output gets a default before any branch; a path that
   // leaves a variable unassigned would infer a latch.
   always_comb begin
      any_valid = 1'b0;
      winner    = '0;
      idx       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (bus.req_valid[idx]) begin
            any_valid = 1'b1;
            winner    = idx[PTR_W-1:0];
         end
      end
   end

   assign accept        = any_valid & ~flush;
   assign bus.req_ready = accept ? (NUM_REQ'(1) << winner) : '0;

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   // NOTE: the operand/tag registers are reset along with the valid bits so that
   // every output reads 0 during and right after reset, not just the valids.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr  <= '0;
         v1   <= 1'b0;
         id1  <= '0;
         op1  <= '0;
         a1   <= '0;
         b1   <= '0;
         tag1 <= '0;
         err1 <= 1'b0;
         v2   <= 1'b0;
         id2  <= '0;
         tag2 <= '0;
         err2 <= 1'b0;
      end else begin
         // accept is already 0 under flush, which empties S1
         v1 <= accept;
         if (accept) begin
            id1  <= winner;
            op1  <= bus.req_op[int'(winner)*4 +: 4];
            a1   <= bus.req_a[int'(winner)*16 +: 16];
            b1   <= bus.req_b[int'(winner)*16 +: 16];
            tag1 <= bus.req_tag[int'(winner)*TAG_W +: TAG_W];
            err1 <= illegal_op(bus.req_op[int'(winner)*4 +: 4]);
            ptr  <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
         end
         v2   <= v1 & ~flush;
         id2  <= id1;
         tag2 <= tag1;
         err2 <= err1;
      end
   end

   // Illegal ops are held back from the ALU; it sees op 0 and idles.
   always_comb begin
      alu_op_o = '0;
      alu_a_o  = '0;
      alu_b_o  = '0;
      if (v1 && !err1) begin
         alu_op_o = op1;
         alu_a_o  = a1;
         alu_b_o  = b1;
      end
   end

   // The ALU's own zero flag can lag the result, so it is rebuilt here.
   always_comb begin
      bus.rsp_valid = '0;
      bus.rsp_data  = '0;
      bus.rsp_flags = '0;
      bus.rsp_tag   = '0;
      bus.rsp_err   = 1'b0;
      if (v2) begin
         bus.rsp_valid = NUM_REQ'(1) << id2;
         bus.rsp_tag   = tag2;
         bus.rsp_err   = err2;
         if (!err2) begin
            bus.rsp_data  = alu_out_i;
            bus.rsp_flags = {alu_flags_i[3:1], alu_out_i == 16'h0};
         end
      end
   end

endmodule
